// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry controller.
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [KEY_W-1:0] CLR_CODE_DEF = 4'hF;
  localparam logic [KEY_W-1:0] BS_CODE_DEF  = 4'hE;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

endpackage

// File: rtl/digit_shift_buffer.sv
// DEPTH-digit entry buffer, newest digit at index 0; push shifts up, pop shifts down.
// Buffer updates and the overflow pulse land on the edge that samples push/pop/clr.
module digit_shift_buffer
  import keypad_pkg::*;
#(
  parameter int DEPTH     = 6,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr,
  input  logic [KEY_W-1:0]     data,
  output logic [DEPTH-1:0]     buf_flag,
  output logic [KEY_W*DEPTH-1:0] buf_code,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] flag_q;
  logic [KEY_W-1:0] code_q [DEPTH];
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) code_q[i] <= '0;
    end else begin
      overflow <= 1'b0;
      if (clr) begin
        flag_q <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) code_q[i] <= '0;
      end else if (pop) begin
        if (count != '0) begin
          for (int i = 0; i < DEPTH - 1; i++) code_q[i] <= code_q[i+1];
          code_q[DEPTH-1] <= '0;
          flag_q          <= flag_q >> 1;
          count           <= count - 1'b1;
        end
      end else if (push) begin
        // With OVERWRITE the shift itself discards the oldest digit.
        if (count == CNT_W'(DEPTH) && !OVERWRITE) begin
          overflow <= 1'b1;
        end else begin
          for (int i = DEPTH - 1; i > 0; i--) code_q[i] <= code_q[i-1];
          code_q[0] <= data;
          flag_q    <= (flag_q << 1) | DEPTH'(1);
          if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
        end
      end
    end
  end

  assign buf_flag = flag_q;

  always_comb begin
    buf_code = '0;
    for (int i = 0; i < DEPTH; i++) buf_code[KEY_W*i +: KEY_W] = code_q[i];
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Row scan, debounce and entry buffering for a ROWS x COLS keypad on the system clock.
// Optional KEYPAD_FUNC_KEYS_EN turns CLR_CODE/BS_CODE into clear/backspace commands.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int               ROWS      = 4,
  parameter int               COLS      = 4,
  parameter int               DEPTH     = 6,
  parameter int               SCAN_DIV  = 50000,
  parameter int               DEB_TICKS = 4,
  parameter bit               OVERWRITE = 1'b1,
  parameter logic [KEY_W-1:0] CLR_CODE  = CLR_CODE_DEF,
  parameter logic [KEY_W-1:0] BS_CODE   = BS_CODE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS-1:0]        col_in,
  output logic [ROWS-1:0]        row_sel,
  output logic                   press,
  output logic [KEY_W-1:0]       scan_code,
  output logic                   key_valid,
  output logic                   overflow,
  output logic [DEPTH-1:0]       buf_flag,
  output logic [KEY_W*DEPTH-1:0] buf_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int DEB_W = $clog2(DEB_TICKS + 1);

`ifdef KEYPAD_FUNC_KEYS_EN
  localparam bit FUNC_EN = 1'b1;
`else
  localparam bit FUNC_EN = 1'b0;
`endif

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  state_t           state;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [DEB_W-1:0] deb;
  logic [COL_W-1:0] col_low;
  logic             col_any;
  logic [ROW_W-1:0] next_row;
  logic [KEY_W-1:0] key_code;
  logic             same_low;
  logic             accept;
  logic             is_clr, is_bs;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt <= '0;
    else      div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Descending loop so the lowest pressed column ends up winning.
  always_comb begin
    col_low = '0;
    col_any = 1'b0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_in[c]) begin
        col_low = COL_W'(c);
        col_any = 1'b1;
      end
    end
  end

  assign next_row = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign row_sel  = ~(ROWS'(1) << row_q);
  assign key_code = KEY_W'(int'(row_q) * COLS + int'(col_q));
  assign same_low = col_any && (col_low == col_q);
  assign accept   = tick && (state == DEBOUNCE) && same_low && (deb == DEB_W'(DEB_TICKS));

  assign is_clr = FUNC_EN && (key_code == CLR_CODE);
  assign is_bs  = FUNC_EN && (key_code == BS_CODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      row_q     <= '0;
      col_q     <= '0;
      deb       <= '0;
      press     <= 1'b0;
      key_valid <= 1'b0;
      scan_code <= '0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (col_any) begin
              col_q <= col_low;
              deb   <= DEB_W'(1);
              state <= DEBOUNCE;
            end else begin
              row_q <= next_row;
            end
          end
          DEBOUNCE: begin
            if (!same_low) begin
              state <= SCAN;
            end else if (accept) begin
              state     <= HELD;
              key_valid <= 1'b1;
              press     <= 1'b1;
              scan_code <= key_code;
              deb       <= '0;
            end else begin
              deb <= deb + 1'b1;
            end
          end
          HELD: begin
            // deb now counts consecutive released ticks on the latched column.
            if (!col_in[col_q]) begin
              deb <= '0;
            end else if (deb == DEB_W'(DEB_TICKS - 1)) begin
              press <= 1'b0;
              deb   <= '0;
              row_q <= next_row;
              state <= SCAN;
            end else begin
              deb <= deb + 1'b1;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  digit_shift_buffer #(
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (accept && !is_clr && !is_bs),
    .pop      (accept && is_bs),
    .clr      (accept && is_clr),
    .data     (key_code),
    .buf_flag (buf_flag),
    .buf_code (buf_code),
    .overflow (overflow)
  );

endmodule
